// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback over a single shared memory port, counts retired instructions and
// halts on illegal opcodes, SYSTEM instructions or memory timeouts.
module multicycle_controller #(
  parameter int unsigned COUNT_BITS  = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic                  dec_wEn,
  input  logic                  dec_mem_wEn,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_addr_sel,
  output logic                  mem_we,
  output logic                  ir_wEn,
  output logic                  pc_wEn,
  output logic                  rf_wEn,
  output logic                  halted,
  output logic [1:0]            trap_cause,
  output logic [2:0]            state,
  output logic [COUNT_BITS-1:0] retired
);

  localparam int unsigned TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_SYSTEM  = 2'd3
  } cause_t;

  state_t                  state_q, state_d;
  cause_t                  cause_q, cause_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [COUNT_BITS-1:0]   ret_q, ret_d;

  logic op_legal, op_system, op_mem;
  logic tmo_hit;

  logic req_c, sel_c, we_c, ir_c, pc_c, rf_c;

  assign tmo_hit = (tmo_q == TMO_LAST);

  // Classify the opcode held in the instruction register.
  always_comb begin
    op_legal  = 1'b0;
    op_system = 1'b0;
    op_mem    = 1'b0;
    case (opcode)
      OP_REG, OP_IMM, OP_BRANCH, OP_JALR, OP_JAL, OP_AUIPC, OP_LUI:
        op_legal = 1'b1;
      OP_LOAD, OP_STORE: begin
        op_legal = 1'b1;
        op_mem   = 1'b1;
      end
      OP_SYSTEM:
        op_system = 1'b1;
      default: ;
    endcase
  end

  // Next-state, counter and strobe logic for the instruction sequence.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    tmo_d   = tmo_q;
    ret_d   = ret_q;
    req_c   = 1'b0;
    sel_c   = 1'b0;
    we_c    = 1'b0;
    ir_c    = 1'b0;
    pc_c    = 1'b0;
    rf_c    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        tmo_d   = '0;
      end
      FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_c    = 1'b1;
          state_d = DECODE;
        end else if (tmo_hit) begin
          state_d = HALT;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DECODE: begin
        if (op_legal) begin
          state_d = EXECUTE;
        end else if (op_system) begin
          state_d = HALT;
          cause_d = CAUSE_SYSTEM;
        end else begin
          state_d = HALT;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      EXECUTE: begin
        if (op_mem) begin
          state_d = MEMORY;
          tmo_d   = '0;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEMORY: begin
        req_c = 1'b1;
        sel_c = 1'b1;
        we_c  = dec_mem_wEn;
        if (mem_ready) begin
          state_d = WRITEBACK;
        end else if (tmo_hit) begin
          state_d = HALT;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WRITEBACK: begin
        rf_c    = dec_wEn;
        pc_c    = 1'b1;
        ret_d   = ret_q + COUNT_BITS'(1);
        state_d = FETCH;
        tmo_d   = '0;
      end
      HALT: ;
      default: begin
        state_d = HALT;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

  // Registered state, trap cause, timeout counter and retire count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      tmo_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      tmo_q   <= tmo_d;
      ret_q   <= ret_d;
    end
  end

  // Strobes are forced low while reset is held, even if the registered
  // state is still mid-request.
  assign mem_req      = req_c & ~reset;
  assign mem_addr_sel = sel_c & ~reset;
  assign mem_we       = we_c  & ~reset;
  assign ir_wEn       = ir_c  & ~reset;
  assign pc_wEn       = pc_c  & ~reset;
  assign rf_wEn       = rf_c  & ~reset;

  assign halted     = (state_q == HALT);
  assign trap_cause = cause_q;
  assign state      = state_q;
  assign retired    = ret_q;

endmodule
